// File: rtl/sprite_pixel_renderer_if.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_pixel_renderer_if
//  Brief    : Locator-to-renderer coordinate bus plus the bitmap ROM port.
//             SPRITE_SIZE_MIRROR feature: define SPRITE_MIRROR_EN to add flip_x.
//  Revision : 1.0  initial release
// ============================================================================
interface sprite_pixel_renderer_if #(
    parameter int FRAME_LEN   = 2,
    parameter int SPRITE_SIZE = 16
);
    localparam int FB = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic                   vsync;
    logic                   anim_en;
    logic [3:0]             xin;
    logic [3:0]             yin;
`ifdef SPRITE_MIRROR_EN
    logic                   flip_x;
`endif
    logic [FB+3:0]          rom_addr;
    logic [SPRITE_SIZE-1:0] rom_data;
    logic [FB-1:0]          frame_idx;
    logic                   pixel_on;
    logic [3:0]             color;

`ifdef SPRITE_MIRROR_EN
    modport master (
        output vsync, anim_en, xin, yin, flip_x, rom_data,
        input  rom_addr, frame_idx, pixel_on, color
    );
    modport slave (
        input  vsync, anim_en, xin, yin, flip_x, rom_data,
        output rom_addr, frame_idx, pixel_on, color
    );
`else
    modport master (
        output vsync, anim_en, xin, yin, rom_data,
        input  rom_addr, frame_idx, pixel_on, color
    );
    modport slave (
        input  vsync, anim_en, xin, yin, rom_data,
        output rom_addr, frame_idx, pixel_on, color
    );
`endif
endinterface
`default_nettype wire

// File: rtl/sprite_pixel_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_pixel_renderer
//  Brief    : Fetches sprite bitmap rows from a sync ROM and emits one colour
//             per pixel clock (2-cycle latency); owns animation frame timing.
//             Optional: SPRITE_MIRROR_EN adds the flip_x horizontal mirror.
//  Revision : 1.0  initial release
// ============================================================================
module sprite_pixel_renderer #(
    parameter int FRAME_LEN     = 2,
    parameter int FRAME_TIME    = 30,
    parameter int SPRITE_SIZE   = 16,
    parameter int PRIMARY_COLOR = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    sprite_pixel_renderer_if.slave bus
);
    localparam int         FB           = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [4:0] c_SIZE       = 5'(SPRITE_SIZE);
    localparam logic [3:0] c_MSB        = 4'(SPRITE_SIZE - 1);
    localparam logic [7:0] c_TICK_LAST  = 8'(FRAME_TIME - 1);
    localparam logic [FB-1:0] c_FRAME_LAST = FB'(FRAME_LEN - 1);
    localparam logic [3:0] c_COLOR      = 4'(PRIMARY_COLOR);

    logic [FB-1:0] r_frame_idx;
    logic [7:0]    r_tick_cnt;
    logic [FB+3:0] r_rom_addr;
    logic [3:0]    r_x_d;
    logic          r_v_d;
    logic          r_flip_d;
    logic          r_pixel_on;
    logic [3:0]    r_color;

    logic          w_inside;
    logic          w_flip;
    logic [15:0]   w_row;
    logic [3:0]    w_bit_idx;
    logic          w_hit;

    assign w_inside = (bus.xin != 4'd0) && (bus.yin != 4'd0) &&
                      ({1'b0, bus.xin} < c_SIZE) && ({1'b0, bus.yin} < c_SIZE);

`ifdef SPRITE_MIRROR_EN
    assign w_flip = bus.flip_x;
`else
    assign w_flip = 1'b0;
`endif

    // Zero-extend the row so a 4-bit index is always in range for any size.
    assign w_row     = 16'(bus.rom_data);
    assign w_bit_idx = r_flip_d ? r_x_d : (c_MSB - r_x_d);
    assign w_hit     = r_v_d & w_row[w_bit_idx];

    // S0: latch the row address with the pre-vsync frame index, so a frame
    // change never tears a pixel already in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rom_addr <= '0;
            r_x_d      <= 4'd0;
            r_v_d      <= 1'b0;
            r_flip_d   <= 1'b0;
        end else begin
            r_rom_addr <= {r_frame_idx, bus.yin};
            r_x_d      <= bus.xin;
            r_v_d      <= w_inside;
            r_flip_d   <= w_flip;
        end
    end

    // S1: ROM data is valid now; select the bit for the buffered column.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pixel_on <= 1'b0;
            r_color    <= 4'd0;
        end else begin
            r_pixel_on <= w_hit;
            r_color    <= w_hit ? c_COLOR : 4'd0;
        end
    end

    // Animation timer: counts enabled vsyncs; a single-frame build keeps
    // frame_idx at zero because c_FRAME_LAST is zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_cnt  <= 8'd0;
            r_frame_idx <= '0;
        end else if (bus.vsync && bus.anim_en) begin
            if (r_tick_cnt == c_TICK_LAST) begin
                r_tick_cnt  <= 8'd0;
                r_frame_idx <= (r_frame_idx == c_FRAME_LAST) ? '0 : r_frame_idx + 1'b1;
            end else begin
                r_tick_cnt  <= r_tick_cnt + 8'd1;
            end
        end
    end

    assign bus.rom_addr  = r_rom_addr;
    assign bus.frame_idx = r_frame_idx;
    assign bus.pixel_on  = r_pixel_on;
    assign bus.color     = r_color;

endmodule
`default_nettype wire

// File: tb/tb_sprite_pixel_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_pixel_renderer
//  Brief    : Directed vectors for sprite_pixel_renderer (default parameters).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sprite_pixel_renderer;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    sprite_pixel_renderer_if #(.FRAME_LEN(2), .SPRITE_SIZE(16)) bus ();

    sprite_pixel_renderer #(
        .FRAME_LEN(2), .FRAME_TIME(30), .SPRITE_SIZE(16), .PRIMARY_COLOR(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_flip(input logic f);
`ifdef SPRITE_MIRROR_EN
        bus.flip_x = f;
`else
        if (f) $display("note: flip ignored in this build");
`endif
    endtask

    // One isolated pixel: drive coords, then the ROM row one cycle later.
    task automatic pix(input string tag, input logic [3:0] x, input logic [3:0] y,
                       input logic [15:0] row, input logic f,
                       input logic [4:0] exp_addr, input logic exp_on);
        @(negedge clk);
        bus.xin = x;
        bus.yin = y;
        set_flip(f);
        @(negedge clk);
        check_vec({tag, "_addr"}, 32'(bus.rom_addr), 32'(exp_addr));
        bus.rom_data = row;
        bus.xin = 4'd0;
        bus.yin = 4'd0;
        set_flip(1'b0);
        @(negedge clk);
        check_vec({tag, "_on"},    32'(bus.pixel_on), 32'(exp_on));
        check_vec({tag, "_color"}, 32'(bus.color),    exp_on ? 32'd1 : 32'd0);
    endtask

    task automatic vs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.vsync = 1'b1;
            @(negedge clk);
            bus.vsync = 1'b0;
        end
    endtask

    initial begin
        n_vec        = 0;
        n_miss       = 0;
        rst_n        = 1'b0;
        bus.vsync    = 1'b0;
        bus.anim_en  = 1'b0;
        bus.xin      = 4'd0;
        bus.yin      = 4'd0;
        bus.rom_data = 16'h0;
        set_flip(1'b0);

        // Reset with random activity on the inputs.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.xin      = 4'($urandom);
            bus.yin      = 4'($urandom);
            bus.rom_data = 16'($urandom);
        end
        @(negedge clk);
        check_vec("rst_pixel_on", 32'(bus.pixel_on),  32'd0);
        check_vec("rst_color",    32'(bus.color),     32'd0);
        check_vec("rst_frame",    32'(bus.frame_idx), 32'd0);
        check_vec("rst_addr",     32'(bus.rom_addr),  32'd0);
        bus.xin = 4'd0;
        bus.yin = 4'd0;
        rst_n   = 1'b1;

        // Basic pixels: bit index is 15 - x.
        pix("p3_5",   4'd3,  4'd5,  16'h1000, 1'b0, 5'd5,  1'b1);
        pix("p0_7",   4'd0,  4'd7,  16'hFFFF, 1'b0, 5'd7,  1'b0);
        pix("p7_0",   4'd7,  4'd0,  16'hFFFF, 1'b0, 5'd0,  1'b0);
        pix("p3_hole",4'd3,  4'd2,  16'hEFFF, 1'b0, 5'd2,  1'b0);
        pix("p15_15", 4'd15, 4'd15, 16'h0001, 1'b0, 5'd15, 1'b1);
        pix("p1_1",   4'd1,  4'd1,  16'h4000, 1'b0, 5'd1,  1'b1);
        pix("p1_miss",4'd1,  4'd1,  16'hBFFF, 1'b0, 5'd1,  1'b0);

        // Reset mid-pipeline drops the in-flight pixel.
        @(negedge clk);
        bus.xin = 4'd3;
        bus.yin = 4'd5;
        @(negedge clk);
        bus.rom_data = 16'h1000;
        bus.xin = 4'd0;
        bus.yin = 4'd0;
        rst_n   = 1'b0;
        @(negedge clk);
        check_vec("midrst_on", 32'(bus.pixel_on), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_vec("midrst_on2", 32'(bus.pixel_on), 32'd0);

        // Animation timing.
        bus.anim_en = 1'b1;
        vs_pulses(29);
        check_vec("anim_29",  32'(bus.frame_idx), 32'd0);
        vs_pulses(1);
        check_vec("anim_30",  32'(bus.frame_idx), 32'd1);
        pix("f1_pix", 4'd3, 4'd5, 16'h1000, 1'b0, 5'd21, 1'b1);
        vs_pulses(29);
        check_vec("anim_59",  32'(bus.frame_idx), 32'd1);
        vs_pulses(1);
        check_vec("anim_60",  32'(bus.frame_idx), 32'd0);

        // Hold: tick count must survive 50 disabled vsyncs.
        vs_pulses(29);
        bus.anim_en = 1'b0;
        vs_pulses(50);
        check_vec("hold_frame", 32'(bus.frame_idx), 32'd0);
        bus.anim_en = 1'b1;
        vs_pulses(1);
        check_vec("resume_frame", 32'(bus.frame_idx), 32'd1);

        // Vsync coincident with an inside pixel: address uses the old frame.
        vs_pulses(29);
        @(negedge clk);
        bus.vsync = 1'b1;
        bus.xin   = 4'd3;
        bus.yin   = 4'd5;
        @(negedge clk);
        bus.vsync = 1'b0;
        check_vec("tear_addr",  32'(bus.rom_addr),  32'd21);
        check_vec("tear_frame", 32'(bus.frame_idx), 32'd0);
        bus.rom_data = 16'h1000;
        bus.xin = 4'd0;
        bus.yin = 4'd0;
        @(negedge clk);
        check_vec("tear_on", 32'(bus.pixel_on), 32'd1);

`ifdef SPRITE_MIRROR_EN
        pix("mir_on",  4'd3, 4'd4, 16'h0008, 1'b1, 5'd4, 1'b1);
        pix("mir_off", 4'd3, 4'd4, 16'h0008, 1'b0, 5'd4, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
